ad3542_frame_gen: RTL and testbench
===================================

// Module: ad3542_frame_gen
// PURPOSE
//  Parametrised DAC frame generator feeding N_DEV dual-channel AD3542 interfaces; replaces fixed-level test mux.
//  Produces one packed frame of 2*N_DEV samples per programmable frame period: const, ramp, square, triangle or external stream.
//  Sits between the control/stream source and the per-device ad3542_iface instances; frame_tick marks each update.
// PARAMETERS
//  N_DEV   8   number of AD3542 devices (2 channels each, NCH = 2*N_DEV lanes)
//  DATA_W  16  sample width per lane
//  DIV_W   16  width of frame-period divider
// PORTS
//  clk           in   1             system clock (DAC interface clock domain)
//  reset         in   1             synchronous, active-high reset
//  mode          in   3             0 OFF, 1 CONST, 2 RAMP, 3 SQUARE, 4 TRI, 5 STREAM, 6/7 treated as OFF; pre-synchronised
//  const_val     in   DATA_W        level for CONST, high level for SQUARE
//  step          in   DATA_W        increment for RAMP / TRI
//  rate_div      in   DIV_W         frame period = rate_div+1 clk cycles
//  ext_data      in   NCH*DATA_W    stream frame; lane k at [k*DATA_W +: DATA_W], k = 2*dev+ch
//  ext_valid     in   1             stream frame valid
//  ext_ready     out  1             frame buffer can accept
//  dac_out       out  NCH*DATA_W    registered frame to interfaces, same lane packing
//  frame_tick    out  1             1-cycle pulse, high in the cycle dac_out takes a new frame
//  underrun_cnt  out  16            saturating count of STREAM ticks with empty buffer
// BEHAVIOUR
//  Reset: dac_out=0, frame_tick=0, underrun_cnt=0, ext_ready=0, active mode=OFF, div counter=0, acc=0, dir=up, buffer empty.
//  Divider: cnt counts 0..rate_div; at edge where cnt==rate_div, cnt<=0 and a tick occurs; rate_div=0 -> tick every cycle.
//  rate_div change mid-period: compare uses live value; if cnt>rate_div, cnt runs to wrap then ticks (no forced tick).
//  Tick edge: dac_out loads next frame and frame_tick<=1 (both registered, aligned); otherwise frame_tick<=0, dac_out holds.
//  Mode sampled only at tick. If mode != active mode: active<=mode, acc<=0, dir<=up, dac_out<=entry value:
//   OFF 0; CONST const_val; RAMP 0; SQUARE const_val (phase high); TRI 0; STREAM buffer if full else 0 (+underrun).
//  Same mode at tick, all lanes equal value except STREAM:
//   OFF 0. CONST const_val (tracks live const_val each tick).
//   RAMP acc<=acc+step mod 2^DATA_W (wraps, no saturation).
//   SQUARE alternates 0 / const_val each tick.
//   TRI up: if acc > MAX-step then acc<=MAX, dir<=down else acc+=step; down: if acc<step then acc<=0, dir<=up else acc-=step;
//   MAX = 2^DATA_W-1; step=0 holds value.
//   STREAM: buffer full -> dac_out<=buffer, buffer emptied; empty -> dac_out holds, underrun_cnt+=1 (saturates 0xFFFF).
//  Stream buffer: single frame, NCH*DATA_W bits. ext_ready = !reset && mode==STREAM && !buf_full (comb from regs/inputs).
//   Handshake ext_valid&&ext_ready loads buffer, buf_full<=1. ext_valid without ready ignored; ext_data may change freely.
//   Handshake on same edge as empty-buffer tick: tick counts underrun, data lands in buffer for next tick.
//   mode input != STREAM: buffer flushed (buf_full<=0) each cycle.
//  Latency: stream frame accepted at edge E appears on dac_out at first tick edge after E (>=1 cycle).
//  Reset mid-operation: all state cleared at next edge; pending buffer discarded; first tick after release at cnt==rate_div.
// TESTING
//  1 reset; mode=1, const_val=7FFF, rate_div=3 -> frame_tick every 4 clk, all 16 lanes 7FFF from first tick.
//  2 mode=2, step=4000, rate_div=0 -> dac_out 0000,4000,8000,C000,0000 on successive cycles (wrap).
//  3 mode=4, step=6000, rate_div=0 -> 0000,6000,C000,FFFF,9FFF,3FFF,0000,6000.
//  4 mode=5: push frame A (lane k = k*0x1111), tick -> dac_out=A, ext_ready low after push, high after tick;
//    no push before next tick -> dac_out holds A, underrun_cnt=1.
//  5 RAMP running, switch mode to 1 mid-period -> dac_out unchanged until next tick, then const_val;
//    back to 2 -> ramp restarts at 0000.
//  6 STREAM with buffer full, assert reset 1 cycle -> next cycle dac_out=0, ext_ready=0, underrun_cnt=0;
//    after release first tick underruns.

Source files
------------

// File: rtl/ad3542_frame_gen.sv
// Frame generator for N_DEV dual-channel AD3542 DACs: one packed frame of 2*N_DEV lanes per
// programmable period, sourced from a constant, ramp, square, triangle or an external stream.
module ad3542_frame_gen #(
    parameter int N_DEV  = 8,
    parameter int DATA_W = 16,
    parameter int DIV_W  = 16,
    localparam int NCH     = 2 * N_DEV,
    localparam int FRAME_W = NCH * DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic [DATA_W-1:0]  const_val,
    input  logic [DATA_W-1:0]  step,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic [FRAME_W-1:0] ext_data,
    input  logic               ext_valid,
    output logic               ext_ready,
    output logic [FRAME_W-1:0] dac_out,
    output logic               frame_tick,
    output logic [15:0]        underrun_cnt
);

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_CONST  = 3'd1,
        M_RAMP   = 3'd2,
        M_SQUARE = 3'd3,
        M_TRI    = 3'd4,
        M_STREAM = 3'd5
    } mode_e;

    localparam logic [DATA_W-1:0] DMAX = '1;

    function automatic logic [FRAME_W-1:0] fill(input logic [DATA_W-1:0] v);
        fill = {NCH{v}};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Returns {dir_down, acc}; clamps at the rails and reverses direction there.
    function automatic logic [DATA_W:0] tri_next(input logic [DATA_W-1:0] acc,
                                                 input logic              down,
                                                 input logic [DATA_W-1:0] stp);
        if (!down) begin
            if (acc > DMAX - stp) tri_next = {1'b1, DMAX};
            else                  tri_next = {1'b0, acc + stp};
        end else begin
            if (acc < stp)        tri_next = {1'b0, {DATA_W{1'b0}}};
            else                  tri_next = {1'b1, acc - stp};
        end
    endfunction

    logic [DIV_W-1:0]   cnt_q, cnt_d;
    mode_e              active_q, active_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               down_q, down_d;
    logic               phase_q, phase_d;
    logic [FRAME_W-1:0] dac_q, dac_d;
    logic               tick_q, tick_d;
    logic [15:0]        und_q, und_d;
    logic [FRAME_W-1:0] buf_q, buf_d;
    logic               full_q, full_d;

    logic               tick;
    logic               consume;
    logic               ready;
    mode_e              mode_n;
    logic [DATA_W-1:0]  ramp_nx;
    logic [DATA_W:0]    tri_r;

    assign ready        = !reset && (mode == M_STREAM) && !full_q;
    assign ext_ready    = ready;
    assign dac_out      = dac_q;
    assign frame_tick   = tick_q;
    assign underrun_cnt = und_q;

    always_comb begin
        mode_n   = (mode > M_STREAM) ? M_OFF : mode_e'(mode);
        tick     = (cnt_q == rate_div);
        cnt_d    = tick ? '0 : cnt_q + DIV_W'(1);
        ramp_nx  = acc_q + step;
        tri_r    = tri_next(acc_q, down_q, step);

        active_d = active_q;
        acc_d    = acc_q;
        down_d   = down_q;
        phase_d  = phase_q;
        dac_d    = dac_q;
        tick_d   = 1'b0;
        und_d    = und_q;
        buf_d    = buf_q;
        full_d   = full_q;
        consume  = 1'b0;

        if (tick) begin
            tick_d = 1'b1;
            if (mode_n != active_q) begin
                // Mode entry: restart generator state and emit the entry value.
                active_d = mode_n;
                acc_d    = '0;
                down_d   = 1'b0;
                phase_d  = 1'b1;
                case (mode_n)
                    M_CONST, M_SQUARE: dac_d = fill(const_val);
                    M_STREAM: begin
                        if (full_q) begin
                            dac_d   = buf_q;
                            consume = 1'b1;
                        end else begin
                            dac_d = '0;
                            und_d = sat_inc(und_q);
                        end
                    end
                    default: dac_d = '0;
                endcase
            end else begin
                case (active_q)
                    M_CONST: dac_d = fill(const_val);
                    M_RAMP: begin
                        acc_d = ramp_nx;
                        dac_d = fill(ramp_nx);
                    end
                    M_SQUARE: begin
                        phase_d = !phase_q;
                        dac_d   = phase_q ? '0 : fill(const_val);
                    end
                    M_TRI: begin
                        down_d = tri_r[DATA_W];
                        acc_d  = tri_r[DATA_W-1:0];
                        dac_d  = fill(tri_r[DATA_W-1:0]);
                    end
                    M_STREAM: begin
                        if (full_q) begin
                            dac_d   = buf_q;
                            consume = 1'b1;
                        end else begin
                            und_d = sat_inc(und_q);
                        end
                    end
                    default: dac_d = '0;
                endcase
            end
        end

        // A load can never coincide with a consume: loading needs the buffer empty.
        if (mode != M_STREAM) begin
            full_d = 1'b0;
        end else if (consume) begin
            full_d = 1'b0;
        end else if (ext_valid && ready) begin
            buf_d  = ext_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            active_q <= M_OFF;
            acc_q    <= '0;
            down_q   <= 1'b0;
            phase_q  <= 1'b0;
            dac_q    <= '0;
            tick_q   <= 1'b0;
            und_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            acc_q    <= acc_d;
            down_q   <= down_d;
            phase_q  <= phase_d;
            dac_q    <= dac_d;
            tick_q   <= tick_d;
            und_q    <= und_d;
            full_q   <= full_d;
        end
    end

    // Buffer contents are qualified by full_q, so they need no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_ad3542_frame_gen.sv
// Bench for ad3542_frame_gen: integer-level reference model compared every cycle,
// plus directed scenarios with literal expected frames.
module tb_ad3542_frame_gen;

    localparam int N_DEV   = 8;
    localparam int DATA_W  = 16;
    localparam int DIV_W   = 16;
    localparam int NCH     = 2 * N_DEV;
    localparam int FRAME_W = NCH * DATA_W;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         mode;
    logic [DATA_W-1:0]  const_val;
    logic [DATA_W-1:0]  step;
    logic [DIV_W-1:0]   rate_div;
    logic [FRAME_W-1:0] ext_data;
    logic               ext_valid;
    logic               ext_ready;
    logic [FRAME_W-1:0] dac_out;
    logic               frame_tick;
    logic [15:0]        underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ad3542_frame_gen #(.N_DEV(N_DEV), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .const_val   (const_val),
        .step        (step),
        .rate_div    (rate_div),
        .ext_data    (ext_data),
        .ext_valid   (ext_valid),
        .ext_ready   (ext_ready),
        .dac_out     (dac_out),
        .frame_tick  (frame_tick),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [FRAME_W-1:0] rep(input logic [DATA_W-1:0] v);
        rep = {NCH{v}};
    endfunction

    function automatic void chk(input string name, input logic [FRAME_W-1:0] act,
                                input logic [FRAME_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: plain integer arithmetic over the frame-generation rules.
    int                 m_cnt, m_act, m_val;
    bit                 m_up, m_hi, m_full;
    logic [FRAME_W-1:0] m_buf, e_dac;
    bit                 e_tick;
    int                 e_und;

    always @(posedge clk) begin
        int  nm;
        bit  tk, hs, took;
        if (reset) begin
            m_cnt = 0; m_act = 0; m_val = 0; m_up = 1; m_hi = 1; m_full = 0;
            e_dac = '0; e_tick = 0; e_und = 0;
        end else begin
            tk    = (m_cnt == int'(rate_div));
            hs    = ext_valid && (mode == 3'd5) && !m_full;
            took  = 0;
            m_cnt = tk ? 0 : (m_cnt + 1) % 65536;
            e_tick = tk;
            if (tk) begin
                nm = (mode > 3'd5) ? 0 : int'(mode);
                if (nm != m_act) begin
                    m_act = nm; m_val = 0; m_up = 1; m_hi = 1;
                    if (nm == 1 || nm == 3) e_dac = rep(const_val);
                    else if (nm == 5) begin
                        if (m_full) begin e_dac = m_buf; took = 1; end
                        else begin e_dac = '0; e_und = (e_und == 65535) ? 65535 : e_und + 1; end
                    end else e_dac = '0;
                end else begin
                    case (m_act)
                        1: e_dac = rep(const_val);
                        2: begin
                            m_val = (m_val + int'(step)) % 65536;
                            e_dac = rep(DATA_W'(m_val));
                        end
                        3: begin
                            m_hi  = !m_hi;
                            e_dac = m_hi ? rep(const_val) : '0;
                        end
                        4: begin
                            if (m_up) begin
                                m_val = m_val + int'(step);
                                if (m_val > 65535) begin m_val = 65535; m_up = 0; end
                            end else begin
                                m_val = m_val - int'(step);
                                if (m_val < 0) begin m_val = 0; m_up = 1; end
                            end
                            e_dac = rep(DATA_W'(m_val));
                        end
                        5: begin
                            if (m_full) begin e_dac = m_buf; took = 1; end
                            else e_und = (e_und == 65535) ? 65535 : e_und + 1;
                        end
                        default: e_dac = '0;
                    endcase
                end
            end
            if (mode != 3'd5) m_full = 0;
            else if (took) m_full = 0;
            else if (hs) begin m_buf = ext_data; m_full = 1; end
        end
    end

    always @(negedge clk) begin
        chk("model_dac", dac_out, e_dac);
        chk("model_tick", FRAME_W'(frame_tick), FRAME_W'(e_tick));
        chk("model_underrun", FRAME_W'(underrun_cnt), FRAME_W'(e_und));
        chk("model_ready", FRAME_W'(ext_ready),
            FRAME_W'(!reset && mode == 3'd5 && !m_full));
    end

    task automatic wait_tick(input int maxc, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (frame_tick !== 1'b1 && cycles < maxc);
        if (frame_tick !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles (t=%0t)", maxc, $time);
        end
    endtask

    logic [FRAME_W-1:0] fa, fb, fc;
    logic [DATA_W-1:0]  ramp_exp [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
    logic [DATA_W-1:0]  tri_exp  [8] = '{16'h0000, 16'h6000, 16'hC000, 16'hFFFF,
                                         16'h9FFF, 16'h3FFF, 16'h0000, 16'h6000};

    initial begin
        int c;
        for (int k = 0; k < NCH; k++) fa[k*DATA_W +: DATA_W] = DATA_W'(k * 16'h1111);
        fb = ~fa;
        fc = {fa[FRAME_W/2-1:0], fb[FRAME_W-1:FRAME_W/2]};

        reset = 1; mode = 0; const_val = 0; step = 0; rate_div = 0;
        ext_data = '0; ext_valid = 0;
        repeat (2) @(negedge clk);
        chk("reset_dac", dac_out, '0);
        chk("reset_tick", FRAME_W'(frame_tick), '0);
        chk("reset_underrun", FRAME_W'(underrun_cnt), '0);
        chk("reset_ready", FRAME_W'(ext_ready), '0);

        // CONST at a 4-cycle period
        mode = 1; const_val = 16'h7FFF; rate_div = 3; reset = 0;
        wait_tick(20, c);
        chk("const_first_gap", FRAME_W'(c), FRAME_W'(4));
        chk("const_frame", dac_out, rep(16'h7FFF));
        wait_tick(20, c);
        chk("const_period", FRAME_W'(c), FRAME_W'(4));
        chk("const_frame2", dac_out, rep(16'h7FFF));

        // RAMP every cycle, wrapping
        rate_div = 0; mode = 2; step = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ramp_seq", dac_out, rep(ramp_exp[i]));
        end

        // TRI clamps at both rails
        mode = 4; step = 16'h6000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("tri_seq", dac_out, rep(tri_exp[i]));
        end

        // STREAM: push A, tick takes it, next tick underruns and holds
        mode = 5; rate_div = 5; ext_valid = 1; ext_data = fa;
        @(negedge clk);
        ext_valid = 0;
        chk("stream_ready_after_push", FRAME_W'(ext_ready), '0);
        wait_tick(20, c);
        chk("stream_frame_a", dac_out, fa);
        chk("stream_ready_after_tick", FRAME_W'(ext_ready), FRAME_W'(1));
        chk("stream_no_underrun", FRAME_W'(underrun_cnt), '0);
        wait_tick(20, c);
        chk("stream_hold_a", dac_out, fa);
        chk("stream_underrun_1", FRAME_W'(underrun_cnt), FRAME_W'(1));

        // RAMP then CONST mid-period, then back to RAMP
        mode = 2; step = 16'h0100; rate_div = 3;
        wait_tick(20, c);
        chk("ramp_entry", dac_out, rep(16'h0000));
        wait_tick(20, c);
        chk("ramp_step", dac_out, rep(16'h0100));
        @(negedge clk);
        mode = 1; const_val = 16'h1234;
        @(negedge clk);
        chk("midperiod_hold", dac_out, rep(16'h0100));
        wait_tick(20, c);
        chk("switch_const", dac_out, rep(16'h1234));
        mode = 2;
        wait_tick(20, c);
        chk("ramp_restart", dac_out, rep(16'h0000));
        wait_tick(20, c);
        chk("ramp_restart_step", dac_out, rep(16'h0100));

        // SQUARE alternation, then mode 7 behaves as OFF
        mode = 3; const_val = 16'hA5A5; rate_div = 1;
        wait_tick(20, c);
        chk("square_entry", dac_out, rep(16'hA5A5));
        wait_tick(20, c);
        chk("square_low", dac_out, rep(16'h0000));
        wait_tick(20, c);
        chk("square_high", dac_out, rep(16'hA5A5));
        mode = 7;
        wait_tick(20, c);
        chk("mode7_off", dac_out, '0);

        // STREAM with full buffer, then 1-cycle reset
        mode = 5; rate_div = 3; ext_valid = 1; ext_data = fb;
        @(negedge clk);
        ext_valid = 0;
        wait_tick(20, c);
        chk("stream_frame_b", dac_out, fb);
        ext_valid = 1; ext_data = fc;
        @(negedge clk);
        ext_valid = 0;
        reset = 1;
        @(negedge clk);
        chk("midreset_dac", dac_out, '0);
        chk("midreset_ready", FRAME_W'(ext_ready), '0);
        chk("midreset_underrun", FRAME_W'(underrun_cnt), '0);
        reset = 0;
        wait_tick(20, c);
        chk("post_reset_gap", FRAME_W'(c), FRAME_W'(4));
        chk("post_reset_dac", dac_out, '0);
        chk("post_reset_underrun", FRAME_W'(underrun_cnt), FRAME_W'(1));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
